// File: rtl/memarb.sv
// Round-robin arbiter sharing one mem controller port among PORTS DMA requesters.
// Define MEMARB_PRIO_EN to give port 0 strict priority over the round-robin ports.
module memarb #(
  parameter int PORTS = 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [23*PORTS-1:0]   raddr,
  input  logic [32*PORTS-1:0]   rwdata,
  input  logic [2*PORTS-1:0]    rlen,
  input  logic [PORTS-1:0]      rwr,
  input  logic [PORTS-1:0]      rreq,
  output logic [PORTS-1:0]      rack,
  output logic [PORTS-1:0]      rready,
  output logic [31:0]           rdata,
  output logic [22:0]           maddr,
  output logic [31:0]           mwdata,
  output logic [1:0]            mlen,
  output logic                  mwr,
  output logic                  mreq,
  input  logic                  mack,
  input  logic                  mready,
  input  logic [31:0]           mrdata,
  output logic [1:0]            dbg_state
);

  localparam int GW = (PORTS > 1) ? $clog2(PORTS) : 1;

  // Handshake: a requester holds rreq (and addr/len/wr) high until rack pulses;
  // rready strobes each data beat, during which wdata must be valid / rdata is sampled.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMD  = 2'd1,
    S_DATA = 2'd2
  } state_t;

  state_t          state, state_nx;
  logic [GW-1:0]   gnt, gnt_nx;
  logic [GW-1:0]   last, last_nx;
  logic [GW-1:0]   pick, idx, last_done;
  logic            found;
  logic [1:0]      blen, blen_nx;
  logic [2:0]      bcnt, bcnt_nx;
  logic [2:0]      bfull;
  logic            beat;
  logic            complete;

  // Scan last+1, last+2, ... so the most recently served port goes to the back.
  always_comb begin
    pick  = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 1; k <= PORTS; k++) begin
      idx = GW'((int'(last) + k) % PORTS);
      if (!found && rreq[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
`ifdef MEMARB_PRIO_EN
    if (rreq[0]) begin
      pick  = '0;
      found = 1'b1;
    end
`endif
  end

`ifdef MEMARB_PRIO_EN
  // Display DMA grants leave the rotation of the other ports untouched.
  assign last_done = (gnt == '0) ? last : gnt;
`else
  assign last_done = gnt;
`endif

  assign bfull    = {1'b0, blen} + 3'd1;
  assign beat     = mready && (state != S_IDLE);
  assign bcnt_nx  = (state == S_IDLE) ? bcnt :
                    (beat && (bcnt != bfull)) ? bcnt + 3'd1 : bcnt;
  assign complete = (bcnt_nx == bfull);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= S_IDLE;
      gnt   <= '0;
      last  <= GW'(PORTS - 1);
      blen  <= '0;
      bcnt  <= '0;
    end else begin
      state <= state_nx;
      gnt   <= gnt_nx;
      last  <= last_nx;
      blen  <= blen_nx;
      bcnt  <= (state == S_IDLE) ? 3'd0 : bcnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    gnt_nx   = gnt;
    last_nx  = last;
    blen_nx  = blen;
    rack     = '0;
    rready   = '0;
    mreq     = 1'b0;
    case (state)
      S_IDLE: begin
        if (found) begin
          gnt_nx   = pick;
          blen_nx  = rlen[int'(pick)*2 +: 2];
          state_nx = S_CMD;
        end
      end
      S_CMD: begin
        mreq        = 1'b1;
        rready[gnt] = mready;
        if (mack) begin
          rack[gnt] = 1'b1;
          // A beat coinciding with the ack can finish a single-beat burst here.
          if (complete) begin
            last_nx  = last_done;
            state_nx = S_IDLE;
          end else begin
            state_nx = S_DATA;
          end
        end
      end
      S_DATA: begin
        rready[gnt] = mready;
        if (complete) begin
          last_nx  = last_done;
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign maddr     = raddr[int'(gnt)*23 +: 23];
  assign mwdata    = rwdata[int'(gnt)*32 +: 32];
  assign mlen      = rlen[int'(gnt)*2 +: 2];
  assign mwr       = rwr[gnt];
  assign rdata     = mrdata;
  assign dbg_state = state;

endmodule

// File: tb/tb_memarb.sv
// Self-checking bench for memarb: a 2-port and a 4-port instance, the bench acting as mem,
// with a rotating-priority-list reference model predicting each grant.
module tb_memarb;

  logic        clk = 1'b0;
  logic        rstn;
  logic        sel;
  logic        mack, mready;
  logic [31:0] mrdata;

  logic [22:0] a_addr[4];
  logic [31:0] a_wd[4];
  logic [1:0]  a_len[4];
  logic [3:0]  a_wr, a_req;
  logic [91:0]  f_addr;
  logic [127:0] f_wd;
  logic [7:0]   f_len;

  logic [1:0]  rack2, rready2, st2;
  logic [31:0] rdata2, mwdata2;
  logic [22:0] maddr2;
  logic [1:0]  mlen2;
  logic        mwr2, mreq2;
  logic [3:0]  rack4, rready4;
  logic [1:0]  st4;
  logic [31:0] rdata4, mwdata4;
  logic [22:0] maddr4;
  logic [1:0]  mlen4;
  logic        mwr4, mreq4;

  logic [7:0]  o_rack, o_rready;
  logic [31:0] o_rdata, o_mwdata;
  logic [22:0] o_maddr;
  logic [1:0]  o_mlen, o_state;
  logic        o_mwr, o_mreq;

  int vectors = 0;
  int miscompares = 0;
  int cur_p = 0;
  int order[$];
  logic [2:0] exp_q[$];

  always #5 clk = ~clk;

  always_comb begin
    f_addr = '0;
    f_wd   = '0;
    f_len  = '0;
    for (int i = 0; i < 4; i++) begin
      f_addr[i*23 +: 23] = a_addr[i];
      f_wd[i*32 +: 32]   = a_wd[i];
      f_len[i*2 +: 2]    = a_len[i];
    end
  end

  memarb #(.PORTS(2)) dut2 (
    .clk(clk), .rstn(rstn),
    .raddr(f_addr[45:0]), .rwdata(f_wd[63:0]), .rlen(f_len[3:0]), .rwr(a_wr[1:0]),
    .rreq(sel ? 2'b00 : a_req[1:0]),
    .rack(rack2), .rready(rready2), .rdata(rdata2),
    .maddr(maddr2), .mwdata(mwdata2), .mlen(mlen2), .mwr(mwr2), .mreq(mreq2),
    .mack(mack & ~sel), .mready(mready & ~sel), .mrdata(mrdata),
    .dbg_state(st2)
  );

  memarb #(.PORTS(4)) dut4 (
    .clk(clk), .rstn(rstn),
    .raddr(f_addr), .rwdata(f_wd), .rlen(f_len), .rwr(a_wr),
    .rreq(sel ? a_req : 4'b0000),
    .rack(rack4), .rready(rready4), .rdata(rdata4),
    .maddr(maddr4), .mwdata(mwdata4), .mlen(mlen4), .mwr(mwr4), .mreq(mreq4),
    .mack(mack & sel), .mready(mready & sel), .mrdata(mrdata),
    .dbg_state(st4)
  );

  assign o_rack   = sel ? {4'b0, rack4}   : {6'b0, rack2};
  assign o_rready = sel ? {4'b0, rready4} : {6'b0, rready2};
  assign o_rdata  = sel ? rdata4  : rdata2;
  assign o_mwdata = sel ? mwdata4 : mwdata2;
  assign o_maddr  = sel ? maddr4  : maddr2;
  assign o_mlen   = sel ? mlen4   : mlen2;
  assign o_mwr    = sel ? mwr4    : mwr2;
  assign o_mreq   = sel ? mreq4   : mreq2;
  assign o_state  = sel ? st4     : st2;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Requester protocol: the granted port keeps rreq high while the command is pending.
  always @(negedge clk) begin
    if (rstn === 1'b1 && o_mreq === 1'b1) chk("req_held", 64'(a_req[cur_p]), 64'd1);
  end

  // Reference model: priority list, head is the port served first; a served
  // port moves to the tail together with everything ahead of it.
  function automatic void model_reset(input int n);
    order = {};
    for (int i = 0; i < n; i++) order.push_back(i);
  endfunction

  function automatic int model_pick(input logic [3:0] req);
`ifdef MEMARB_PRIO_EN
    if (req[0]) return 0;
`endif
    foreach (order[i]) if (req[order[i]]) return order[i];
    return -1;
  endfunction

  function automatic void model_grant(input int p);
`ifdef MEMARB_PRIO_EN
    if (p == 0) return;
`endif
    while (order[$] != p) order.push_back(order.pop_front());
  endfunction

  function automatic int onehot_idx(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return 7;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_port(input int i);
    a_addr[i] = 23'($urandom);
    a_wd[i]   = $urandom;
    a_len[i]  = 2'($urandom_range(0, 3));
    a_wr[i]   = 1'($urandom_range(0, 1));
  endtask

  // Called in an IDLE cycle with requests already driven; returns in the idle cycle after the burst.
  task automatic serve(input int ack_dly, input bit coinc, input bit keep);
    int p, nb;
    p = model_pick(a_req);
    if (p < 0) p = 0;
    cur_p = p;
    exp_q.push_back(3'(p));
    step();
    for (int d = 0; d < ack_dly; d++) begin
      mack = 1'b0; mready = 1'b0;
      #1;
      chk("mreq_cmd", 64'(o_mreq), 64'd1);
      chk("maddr", 64'(o_maddr), 64'(a_addr[p]));
      chk("mlen", 64'(o_mlen), 64'(a_len[p]));
      chk("mwr", 64'(o_mwr), 64'(a_wr[p]));
      chk("rack_wait", 64'(o_rack), 64'd0);
      step();
    end
    mack = 1'b1; mready = coinc; mrdata = $urandom;
    if (a_wr[p]) a_wd[p] = $urandom;
    #1;
    chk("mreq_ack", 64'(o_mreq), 64'd1);
    chk("maddr_ack", 64'(o_maddr), 64'(a_addr[p]));
    chk("rack", 64'(o_rack), 64'd1 << p);
    chk("grant", 64'(onehot_idx(o_rack)), 64'(exp_q.pop_front()));
    chk("rready_ack", 64'(o_rready), 64'(coinc) << p);
    if (coinc) begin
      chk("rdata_ack", 64'(o_rdata), 64'(mrdata));
      chk("mwdata_ack", 64'(o_mwdata), 64'(a_wd[p]));
    end
    step();
    mack = 1'b0;
    if (!keep) a_req[p] = 1'b0;
    nb = int'(a_len[p]) + 1 - int'(coinc);
    for (int b = 0; b < nb; b++) begin
      if ($urandom_range(0, 1) == 1) begin
        mready = 1'b0;
        #1;
        chk("rready_gap", 64'(o_rready), 64'd0);
        step();
      end
      mready = 1'b1; mrdata = $urandom;
      if (a_wr[p]) a_wd[p] = $urandom;
      #1;
      chk("rready_beat", 64'(o_rready), 64'd1 << p);
      chk("rdata", 64'(o_rdata), 64'(mrdata));
      chk("mwdata", 64'(o_mwdata), 64'(a_wd[p]));
      chk("mwr_beat", 64'(o_mwr), 64'(a_wr[p]));
      chk("mreq_data", 64'(o_mreq), 64'd0);
      step();
    end
    mready = 1'b0;
    #1;
    chk("idle_mreq", 64'(o_mreq), 64'd0);
    chk("idle_state", 64'(o_state), 64'd0);
    chk("idle_rready", 64'(o_rready), 64'd0);
    model_grant(p);
  endtask

  task automatic rand_round(input int np);
    for (int i = 0; i < np; i++) begin
      if (!a_req[i] && $urandom_range(0, 1) == 1) begin
        rand_port(i);
        a_req[i] = 1'b1;
      end
    end
    if (a_req == 4'b0) begin
      rand_port(0);
      a_req[0] = 1'b1;
    end
    serve($urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b0);
  endtask

  initial begin
    sel = 1'b0; rstn = 1'b0; mack = 1'b0; mready = 1'b0; mrdata = '0;
    a_req = '0; a_wr = '0;
    for (int i = 0; i < 4; i++) rand_port(i);
    model_reset(2);

    // Reset state, with requests present during reset.
    step(); step();
    a_req = 4'b0011;
    step();
    chk("rst_mreq", 64'(o_mreq), 64'd0);
    chk("rst_rack", 64'(o_rack), 64'd0);
    chk("rst_rready", 64'(o_rready), 64'd0);
    chk("rst_state", 64'(o_state), 64'd0);
    a_req = '0;
    rstn = 1'b1;
    step();

    // Single 4-beat read on port 1, mem acks after 2 cycles.
    a_wr[1] = 1'b0; a_len[1] = 2'd3; a_req[1] = 1'b1;
    #1;
    chk("req_cycle_mreq", 64'(o_mreq), 64'd0);
    serve(2, 1'b0, 1'b0);

    // Both ports continuously requesting single beats.
    a_len[0] = 2'd0; a_len[1] = 2'd0; a_wr[1:0] = 2'b00;
    a_req = 4'b0011;
    for (int i = 0; i < 4; i++) serve($urandom_range(0, 2), 1'b0, 1'b1);
    a_req = '0;
    step();

    // Beat coinciding with ack completes a single-beat transaction.
    a_len[0] = 2'd0; a_req[0] = 1'b1;
    serve(1, 1'b1, 1'b0);
    a_len[1] = 2'd0; a_req[1] = 1'b1;
    serve(0, 1'b1, 1'b0);

    // Two-beat write burst on port 0.
    a_wr[0] = 1'b1; a_len[0] = 2'd1; a_req[0] = 1'b1;
    serve($urandom_range(0, 3), 1'b0, 1'b0);

    for (int it = 0; it < 20; it++) rand_round(2);

    // Reset during beat 2 of a 4-beat burst on port 0.
    a_req = '0;
    step();
    a_wr[0] = 1'b1; a_len[0] = 2'd3; a_req[0] = 1'b1; cur_p = 0;
    step();
    #1;
    chk("abort_mreq_cmd", 64'(o_mreq), 64'd1);
    mack = 1'b1;
    step();
    a_req[0] = 1'b0; mack = 1'b0; mready = 1'b1;
    step();
    rstn = 1'b0; a_req[1] = 1'b1; a_len[1] = 2'd1; a_wr[1] = 1'b0;
    step();
    mready = 1'b0;
    #1;
    chk("abort_state", 64'(o_state), 64'd0);
    chk("abort_mreq", 64'(o_mreq), 64'd0);
    chk("abort_rready", 64'(o_rready), 64'd0);
    model_reset(2);
    rstn = 1'b1;
    serve(1, 1'b0, 1'b0);
    a_req[0] = 1'b1;
    serve(1, 1'b0, 1'b0);

    // Four-port instance: leave last at 1, then ports 1 and 3 compete.
    a_req = '0; rstn = 1'b0; sel = 1'b1;
    step(); step();
    rstn = 1'b1;
    model_reset(4);
    step();
    a_len[1] = 2'd0; a_req[1] = 1'b1;
    serve(0, 1'b0, 1'b0);
    a_len[3] = 2'd1; a_req[1] = 1'b1; a_req[3] = 1'b1;
    serve(1, 1'b0, 1'b0);
    serve(1, 1'b0, 1'b0);
    for (int it = 0; it < 16; it++) rand_round(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
